// File: rtl/dmux16_rr_sched_pkg.sv
// Shared constants and FSM state type for the dmux16 round-robin scheduler.
package dmux16_rr_sched_pkg;

  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RELEASE = 2'd3
  } sched_state_t;

endpackage

// File: rtl/dmux16_rr_sched_rr_pick16.sv
// Combinational round-robin priority encoder: first set request at or after ptr, wrapping mod 16.
module rr_pick16
  import dmux16_rr_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  output logic              any,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the closest request to ptr is the last to win.
  always_comb begin
    any  = |req;
    idx  = '0;
    cand = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/dmux16_rr_sched.sv
// Round-robin scheduler sharing one dmux16 among 16 requesters, with guard/release phases around select changes.
// Optional build macro DMUX16_SCHED_LOCK_EN: the active slot extends while the granted request stays high.
module dmux16_rr_sched
  import dmux16_rr_sched_pkg::*;
#(
  parameter int SLOT_CYCLES  = 8,
  parameter int GUARD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              data_in,
  output logic [SEL_W-1:0]  sel,
  output logic              d0,
  output logic [NUM_CH-1:0] gnt,
  output logic              busy
);

  localparam int CNT_MAX = (SLOT_CYCLES > GUARD_CYCLES) ? SLOT_CYCLES : GUARD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);

  sched_state_t      state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              active_q, active_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic              req_hold;

  rr_pick16 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign req_hold = req[sel_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      gnt_q    <= '0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        sel_d    = '0;
        gnt_d    = '0;
        active_d = 1'b0;
        if (pick_any) begin
          sel_d   = pick_idx;
          gnt_d   = NUM_CH'(1) << pick_idx;
          cnt_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!req_hold) begin
          gnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (cnt_q == GUARD_LAST) begin
          active_d = 1'b1;
          cnt_d    = '0;
          state_d  = ST_ACTIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!req_hold) begin
          gnt_d    = '0;
          active_d = 1'b0;
          state_d  = ST_RELEASE;
        end else if (cnt_q == SLOT_LAST) begin
`ifdef DMUX16_SCHED_LOCK_EN
          // Counter parks at the last value; the early-drop branch ends the slot.
          cnt_d = cnt_q;
`else
          gnt_d    = '0;
          active_d = 1'b0;
          state_d  = ST_RELEASE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RELEASE: begin
        gnt_d    = '0;
        active_d = 1'b0;
        sel_d    = '0;
        ptr_d    = sel_q + SEL_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sel  = sel_q;
  assign gnt  = gnt_q;
  assign d0   = data_in & active_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dmux16_rr_sched.sv
// Directed bench for dmux16_rr_sched: reset, single grant, round robin, skip/wrap, glitch guard, mid-slot reset, lock mode.
module tb_dmux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] req = 16'h0000;
  logic        data_in = 1'b0;
  logic [3:0]  sel;
  logic        d0;
  logic [15:0] gnt;
  logic        busy;

  int errors = 0;
  int checks = 0;

  dmux16_rr_sched dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .sel     (sel),
    .d0      (d0),
    .gnt     (gnt),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 16'hFFFF;
    data_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (sel !== 4'd0 || gnt !== 16'h0000 || d0 !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_%0d: sel=%0d gnt=%h d0=%b busy=%b expected all zero", i, sel, gnt, d0, busy);
      end
    end
    rst = 1'b0;
    req = 16'h0000;
    step();
    checks++;
    if (busy !== 1'b0 || gnt !== 16'h0000) begin
      errors++;
      $display("FAIL reset_idle: busy=%b gnt=%h expected 0 0000", busy, gnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 16'h0020;
    data_in = 1'b1;
    step();
    checks++;
    if (sel !== 4'd5 || gnt !== 16'h0020 || d0 !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_grant: sel=%0d gnt=%h d0=%b busy=%b expected 5 0020 0 1", sel, gnt, d0, busy);
    end
    for (int c = 2; c <= 9; c++) begin
      step();
      checks++;
      if (d0 !== 1'b1 || gnt !== 16'h0020) begin
        errors++;
        $display("FAIL single_data_%0d: d0=%b gnt=%h expected 1 0020", c, d0, gnt);
      end
    end
    step();
    checks++;
    if (d0 !== 1'b0 || gnt !== 16'h0000 || busy !== 1'b1 || sel !== 4'd5) begin
      errors++;
      $display("FAIL single_release: d0=%b gnt=%h busy=%b sel=%0d expected 0 0000 1 5", d0, gnt, busy, sel);
    end
    req = 16'h0000;
    for (int c = 11; c <= 12; c++) begin
      step();
      checks++;
      if (busy !== 1'b0 || gnt !== 16'h0000 || d0 !== 1'b0) begin
        errors++;
        $display("FAIL single_idle_%0d: busy=%b gnt=%h d0=%b expected 0 0000 0", c, busy, gnt, d0);
      end
    end
  endtask

  task automatic test_round_robin();
    int off;
    int g;
    logic [3:0] exp_sel;
    do_reset();
    req = 16'hFFFF;
    for (int c = 1; c <= 187; c++) begin
      data_in = c[1];
      step();
      off = (c - 1) % 11;
      g = ((c - 1) / 11) % 16;
      exp_sel = 4'(g);
      checks++;
      if (off == 0) begin
        if (sel !== exp_sel || gnt !== (16'h1 << g) || d0 !== 1'b0) begin
          errors++;
          $display("FAIL rr_grant_c%0d: sel=%0d gnt=%h d0=%b expected %0d %h 0", c, sel, gnt, d0, exp_sel, 16'h1 << g);
        end
      end else if (off <= 8) begin
        if (d0 !== data_in || gnt !== (16'h1 << g)) begin
          errors++;
          $display("FAIL rr_data_c%0d: d0=%b gnt=%h expected %b %h", c, d0, gnt, data_in, 16'h1 << g);
        end
      end else if (off == 9) begin
        if (d0 !== 1'b0 || gnt !== 16'h0000 || busy !== 1'b1 || sel !== exp_sel) begin
          errors++;
          $display("FAIL rr_release_c%0d: d0=%b gnt=%h busy=%b sel=%0d expected 0 0000 1 %0d", c, d0, gnt, busy, sel, exp_sel);
        end
      end else begin
        if (busy !== 1'b0 || gnt !== 16'h0000) begin
          errors++;
          $display("FAIL rr_idle_c%0d: busy=%b gnt=%h expected 0 0000", c, busy, gnt);
        end
      end
    end
    req = 16'h0000;
    step();
  endtask

  task automatic test_skip_wrap();
    logic [3:0] exp_sel;
    do_reset();
    req = 16'h8001;
    data_in = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      step();
      if ((c - 1) % 11 == 0) begin
        exp_sel = (((c - 1) / 11) % 2 == 0) ? 4'd0 : 4'd15;
        checks++;
        if (sel !== exp_sel || gnt !== (16'h1 << exp_sel)) begin
          errors++;
          $display("FAIL skip_grant_c%0d: sel=%0d gnt=%h expected %0d", c, sel, gnt, exp_sel);
        end
      end
    end
    step();
    req = 16'h8000;
    step();
    checks++;
    if (gnt !== 16'h0000 || busy !== 1'b1 || d0 !== 1'b0) begin
      errors++;
      $display("FAIL skip_drop_release: gnt=%h busy=%b d0=%b expected 0000 1 0", gnt, busy, d0);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL skip_drop_idle: busy=%b expected 0", busy);
    end
    step();
    checks++;
    if (sel !== 4'd15 || gnt !== 16'h8000) begin
      errors++;
      $display("FAIL skip_after_drop: sel=%0d gnt=%h expected 15 8000", sel, gnt);
    end
    req = 16'h0000;
  endtask

  task automatic test_glitch();
    logic [3:0] prev_sel;
    logic [3:0] exp_sel;
    int ngrant;
    int highs;
    do_reset();
    req = 16'h1008;
    data_in = 1'b1;
    prev_sel = sel;
    ngrant = 0;
    highs = 0;
    for (int c = 1; c <= 60; c++) begin
      step();
      if (sel !== prev_sel) begin
        checks++;
        if (d0 !== 1'b0) begin
          errors++;
          $display("FAIL glitch_c%0d: d0=%b on select change %0d->%0d expected 0", c, d0, prev_sel, sel);
        end
        if (gnt !== 16'h0000) begin
          exp_sel = (ngrant % 2 == 0) ? 4'd3 : 4'd12;
          checks++;
          if (sel !== exp_sel) begin
            errors++;
            $display("FAIL glitch_order_c%0d: sel=%0d expected %0d", c, sel, exp_sel);
          end
          ngrant++;
        end
      end
      if (gnt !== 16'h0000) begin
        checks++;
        if (gnt !== (16'h1 << sel)) begin
          errors++;
          $display("FAIL glitch_onehot_c%0d: gnt=%h sel=%0d", c, gnt, sel);
        end
      end
      if (d0 === 1'b1) highs++;
      prev_sel = sel;
    end
    checks++;
    if (highs != 44 || ngrant != 6) begin
      errors++;
      $display("FAIL glitch_totals: d0_high=%0d grants=%0d expected 44 6", highs, ngrant);
    end
    req = 16'h0000;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 16'h0040;
    data_in = 1'b1;
    for (int c = 1; c <= 4; c++) step();
    checks++;
    if (busy !== 1'b1 || sel !== 4'd6 || d0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_active: busy=%b sel=%0d d0=%b expected 1 6 1", busy, sel, d0);
    end
    rst = 1'b1;
    req = 16'h0400;
    step();
    checks++;
    if (sel !== 4'd0 || gnt !== 16'h0000 || d0 !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sel=%0d gnt=%h d0=%b busy=%b expected all zero", sel, gnt, d0, busy);
    end
    rst = 1'b0;
    step();
    checks++;
    if (sel !== 4'd10 || gnt !== 16'h0400 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_regrant: sel=%0d gnt=%h busy=%b expected 10 0400 1", sel, gnt, busy);
    end
    req = 16'h0000;
    step();
    checks++;
    if (gnt !== 16'h0000 || busy !== 1'b1 || d0 !== 1'b0 || sel !== 4'd10) begin
      errors++;
      $display("FAIL mid_setup_drop: gnt=%h busy=%b d0=%b sel=%0d expected 0000 1 0 10", gnt, busy, d0, sel);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_setup_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_lock();
    do_reset();
    req = 16'h0004;
    for (int c = 1; c <= 21; c++) begin
      data_in = c[0];
      step();
      if (c >= 2) begin
        checks++;
        if (d0 !== data_in || gnt !== 16'h0004) begin
          errors++;
          $display("FAIL lock_data_c%0d: d0=%b gnt=%h expected %b 0004", c, d0, gnt, data_in);
        end
      end
    end
    req = 16'h0000;
    data_in = 1'b1;
    step();
    checks++;
    if (d0 !== 1'b0 || gnt !== 16'h0000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL lock_release: d0=%b gnt=%h busy=%b expected 0 0000 1", d0, gnt, busy);
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL lock_idle: busy=%b expected 0", busy);
    end
  endtask

  initial begin
    test_reset();
`ifdef DMUX16_SCHED_LOCK_EN
    test_lock();
`else
    test_single();
    test_round_robin();
    test_skip_wrap();
    test_glitch();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
